full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- 1-bit binary full adder: combinational sum/carry core plus a clocked bit-serial accumulation path.
- Combinational core is the primitive for the 4-bit adder/subtractor ripple chain; it must work with clk/rst_n left unconnected.
- Serial path lets one instance add multi-bit operands LSB-first, one bit per clock, with carry held in a register.

Parameters:
- CNT_W, default 8, width of the serial bit counter bit_cnt.
- SERIAL_CIN_INIT, default 0, carry_q value loaded by reset and by serial_clr (1 gives the two's-complement subtract seed).

Ports:
- clk  input  1  rising-edge clock, serial path only.
- rst_n  input  1  asynchronous active-low reset, serial path only.
- A  input  1  addend bit.
- B  input  1  addend bit.
- Cin  input  1  carry-in, combinational core.
- S  output  1  combinational sum, A^B^Cin.
- Cout  output  1  combinational carry, (A&B)|(A&Cin)|(B&Cin).
- serial_en  input  1  advance the serial path this cycle.
- serial_clr  input  1  synchronous clear of the serial state.
- S_q  output  1  registered serial sum bit.
- carry_q  output  1  registered serial carry state.
- bit_cnt  output  CNT_W  serial bits processed since the last clear.

Behaviour:
- Combinational core:
  - S and Cout depend only on A, B, Cin.
  - Zero cycles of latency, no storage.
  - Independent of clk, rst_n, serial_en and serial_clr.
  - X/Z on clk or rst_n must never propagate to S or Cout.
- Truth table, {A,B,Cin} -> {Cout,S}:
  - 000->00, 001->01, 010->01, 011->10
  - 100->01, 101->10, 110->10, 111->11
- Serial sum: s_ser = A^B^carry_q. Serial carry: c_ser = majority(A,B,carry_q). Cin is ignored by the serial path.
- Reset (rst_n low, asynchronous):
  - S_q = 0, carry_q = SERIAL_CIN_INIT, bit_cnt = 0.
  - Held for as long as rst_n is low.
- On the rising clk edge, serial_clr=1 has priority:
  - carry_q = SERIAL_CIN_INIT, S_q = 0, bit_cnt = 0.
  - serial_en is ignored that cycle.
- On the rising clk edge, serial_en=1 with serial_clr=0:
  - S_q = s_ser, carry_q = c_ser, bit_cnt = bit_cnt + 1.
  - bit_cnt wraps modulo 2^CNT_W; there is no saturation flag.
- Both serial_en and serial_clr low: all registers hold.
- Serial result of operand bit k is on S_q one cycle after the serial_en edge that consumed bit k.
- Reset asserted mid-sequence aborts it. After rst_n rises, the first valid edge starts a new sequence from SERIAL_CIN_INIT.
- rst_n is deasserted asynchronously; the integration is responsible for release timing.

Optional Feature:
- Macro FULL_ADDER_SELFCHECK_EN.
- Defined:
  - Adds output err (1 bit), a registered sticky flag.
  - Each cycle, compares {Cout,S} with the 2-bit arithmetic sum A+B+Cin, and {c_ser,s_ser} with A+B+carry_q.
  - Any mismatch sets err on the next rising clk edge.
  - err is cleared only by rst_n low or serial_clr.
  - err resets to 0.
- Not defined:
  - Port err does not exist and no check logic is generated.
  - All other behaviour is identical.

Test Plan:
- Exhaustive combinational sweep, clk/rst_n unconnected: {A,B,Cin} = 0..7, 20 ns per step -> {Cout,S} = 00,01,01,10,01,10,10,11.
- Reset values: rst_n=0 with clk toggling -> S_q=0, carry_q=SERIAL_CIN_INIT, bit_cnt=0, all held. Asserting rst_n=0 between clock edges forces these values immediately.
- Serial add, SERIAL_CIN_INIT=0: 4'b1011 + 4'b0110 LSB-first over 4 enabled cycles -> S_q sequence 1,0,0,0, final carry_q=1 (sum 10001), bit_cnt=4.
- Serial subtract via seed, SERIAL_CIN_INIT=1: 4'b0111 + ~4'b0010 -> S_q sequence 1,0,1,0 (0101), final carry_q=1.
- Priority and hold:
  - serial_en=1 and serial_clr=1 on the same edge -> cleared state, bit_cnt=0.
  - serial_en=0 for 3 cycles -> S_q, carry_q, bit_cnt unchanged.
- Wrap and self-check, CNT_W=2: 5 enabled cycles -> bit_cnt = 0,1,2,3,0,1 sequence ending at 1. With FULL_ADDER_SELFCHECK_EN defined, err stays 0 throughout all scenarios above.

Source files
------------

// File: rtl/full_adder.sv
// 1-bit full adder with a clocked bit-serial accumulation path.
// Define FULL_ADDER_SELFCHECK_EN to add the sticky err output.
module full_adder #(
  parameter int CNT_W           = 8,
  parameter bit SERIAL_CIN_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             Cin,
  output logic             S,
  output logic             Cout,
  input  logic             serial_en,
  input  logic             serial_clr,
  output logic             S_q,
  output logic             carry_q,
  output logic [CNT_W-1:0] bit_cnt
`ifdef FULL_ADDER_SELFCHECK_EN
  ,
  output logic             err
`endif
);

  logic             s_ser;
  logic             c_ser;
  logic             S_d;
  logic             carry_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Pure gates: the core never sees clk or rst_n.
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

  assign s_ser = A ^ B ^ carry_q;
  assign c_ser = (A & B) | (A & carry_q) | (B & carry_q);

  always_comb begin
    S_d     = S_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (serial_clr) begin
      S_d     = 1'b0;
      carry_d = SERIAL_CIN_INIT;
      cnt_d   = '0;
    end else if (serial_en) begin
      S_d     = s_ser;
      carry_d = c_ser;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_q     <= 1'b0;
      carry_q <= SERIAL_CIN_INIT;
      cnt_q   <= '0;
    end else begin
      S_q     <= S_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_cnt = cnt_q;

`ifdef FULL_ADDER_SELFCHECK_EN
  logic [1:0] comb_ref;
  logic [1:0] ser_ref;
  logic       mism;
  logic       err_d;
  logic       err_q;

  assign comb_ref = {1'b0, A} + {1'b0, B} + {1'b0, Cin};
  assign ser_ref  = {1'b0, A} + {1'b0, B} + {1'b0, carry_q};
  assign mism     = ({Cout, S} != comb_ref) | ({c_ser, s_ser} != ser_ref);

  always_comb begin
    err_d = err_q | mism;
    if (serial_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: truth table, serial add/subtract,
// priority, hold, reset and counter wrap against an integer model.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic A = 1'b0, B = 1'b0, Cin = 1'b0;
  logic en = 1'b0, clr = 1'b0;

  logic s0, co0, sq0, cq0;
  logic s1, co1, sq1, cq1;
  logic s2, co2, sq2, cq2;
  logic [7:0] bc0, bc1;
  logic [1:0] bc2;
`ifdef FULL_ADDER_SELFCHECK_EN
  logic err0, err1, err2;
`endif

  int errors = 0;
  int checks = 0;

  // model: operands collected since the last clear
  int      n  = 0;
  longint  av = 0;
  longint  bv = 0;

  always #5 clk = ~clk;

  full_adder #(.CNT_W(8), .SERIAL_CIN_INIT(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Cin(Cin),
    .S(s0), .Cout(co0), .serial_en(en), .serial_clr(clr),
    .S_q(sq0), .carry_q(cq0), .bit_cnt(bc0)
`ifdef FULL_ADDER_SELFCHECK_EN
    , .err(err0)
`endif
  );

  full_adder #(.CNT_W(8), .SERIAL_CIN_INIT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Cin(Cin),
    .S(s1), .Cout(co1), .serial_en(en), .serial_clr(clr),
    .S_q(sq1), .carry_q(cq1), .bit_cnt(bc1)
`ifdef FULL_ADDER_SELFCHECK_EN
    , .err(err1)
`endif
  );

  full_adder #(.CNT_W(2), .SERIAL_CIN_INIT(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Cin(Cin),
    .S(s2), .Cout(co2), .serial_en(en), .serial_clr(clr),
    .S_q(sq2), .carry_q(cq2), .bit_cnt(bc2)
`ifdef FULL_ADDER_SELFCHECK_EN
    , .err(err2)
`endif
  );

  typedef struct {
    logic a;
    logic b;
    logic cin;
    logic cout;
    logic s;
  } vec_t;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint exp_s(input int init);
    longint t;
    t = av + bv + longint'(init);
    return (n == 0) ? 0 : ((t >> (n - 1)) & 1);
  endfunction

  function automatic longint exp_c(input int init);
    longint t;
    t = av + bv + longint'(init);
    return (t >> n) & 1;
  endfunction

  task automatic check_all();
    longint ar;
    ar = longint'(A) + longint'(B) + longint'(Cin);
    chk("u0.S",    longint'(s0),  ar & 1);
    chk("u0.Cout", longint'(co0), ar >> 1);
    chk("u2.S",    longint'(s2),  ar & 1);
    chk("u2.Cout", longint'(co2), ar >> 1);
    chk("u0.S_q",     longint'(sq0), exp_s(0));
    chk("u0.carry_q", longint'(cq0), exp_c(0));
    chk("u0.bit_cnt", longint'(bc0), longint'(n % 256));
    chk("u1.S_q",     longint'(sq1), exp_s(1));
    chk("u1.carry_q", longint'(cq1), exp_c(1));
    chk("u1.bit_cnt", longint'(bc1), longint'(n % 256));
    chk("u2.S_q",     longint'(sq2), exp_s(0));
    chk("u2.carry_q", longint'(cq2), exp_c(0));
    chk("u2.bit_cnt", longint'(bc2), longint'(n % 4));
`ifdef FULL_ADDER_SELFCHECK_EN
    chk("u0.err", longint'(err0), 0);
    chk("u1.err", longint'(err1), 0);
    chk("u2.err", longint'(err2), 0);
`endif
  endtask

  task automatic model_clear();
    n  = 0;
    av = 0;
    bv = 0;
  endtask

  // one clock with the inputs already applied
  task automatic step();
    @(posedge clk);
    if (!rst_n || clr) begin
      model_clear();
    end else if (en) begin
      av = av | (longint'(A) << n);
      bv = bv | (longint'(B) << n);
      n++;
    end
    #1;
    check_all();
  endtask

  task automatic serial_bit(input logic a, input logic b);
    A = a; B = b; en = 1'b1; clr = 1'b0;
    step();
  endtask

  task automatic do_clear();
    en = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  vec_t tt[8];
  logic [3:0] opa, opb;
  logic [3:0] exp_sq;
  int wrap_exp[5];

  initial begin
    tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tt[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tt[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tt[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    wrap_exp = '{1, 2, 3, 0, 1};

    // reset held with clock running, enable asserted
    #1;
    en = 1'b1;
    A = 1'b1; B = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("rst u0.S_q", longint'(sq0), 0);
    chk("rst u1.carry_q", longint'(cq1), 1);
    en = 1'b0;
    A = 1'b0; B = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // exhaustive combinational sweep
    for (int i = 0; i < 8; i++) begin
      A = tt[i].a; B = tt[i].b; Cin = tt[i].cin;
      #20;
      chk($sformatf("tt%0d.Cout", i), longint'(co0),
          longint'(tt[i].cout));
      chk($sformatf("tt%0d.S", i), longint'(s0),
          longint'(tt[i].s));
    end
    Cin = 1'b0;

    // 1011 + 0110 on u0
    do_clear();
    opa = 4'b1011; opb = 4'b0110; exp_sq = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      serial_bit(opa[k], opb[k]);
      chk($sformatf("add bit%0d", k), longint'(sq0),
          longint'(exp_sq[k]));
    end
    chk("add carry", longint'(cq0), 1);
    chk("add cnt", longint'(bc0), 4);

    // hold three cycles
    en = 1'b0; A = 1'b1; B = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("hold cnt", longint'(bc0), 4);
    chk("hold carry", longint'(cq0), 1);
    chk("hold S_q", longint'(sq0), 0);

    // 0111 - 0010 on u1 via carry seed
    do_clear();
    opa = 4'b0111; opb = ~4'b0010; exp_sq = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      serial_bit(opa[k], opb[k]);
      chk($sformatf("sub bit%0d", k), longint'(sq1),
          longint'(exp_sq[k]));
    end
    chk("sub carry", longint'(cq1), 1);

    // clear wins over enable
    A = 1'b1; B = 1'b1; en = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("prio u0.cnt", longint'(bc0), 0);
    chk("prio u0.carry", longint'(cq0), 0);
    chk("prio u1.carry", longint'(cq1), 1);

    // CNT_W=2 wrap
    for (int i = 0; i < 5; i++) begin
      serial_bit(1'(i & 1), 1'b0);
      chk($sformatf("wrap%0d", i), longint'(bc2),
          longint'(wrap_exp[i]));
    end

    // async reset between edges
    serial_bit(1'b1, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("async u0.cnt", longint'(bc0), 0);
    chk("async u0.S_q", longint'(sq0), 0);
    chk("async u1.carry", longint'(cq1), 1);
    chk("async u2.cnt", longint'(bc2), 0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;

    // randomized run against the integer model
    for (int i = 0; i < 400; i++) begin
      A   = 1'($urandom);
      B   = 1'($urandom);
      Cin = 1'($urandom);
      en  = ($urandom % 4) != 0;
      clr = (($urandom % 12) == 0) || (n >= 60);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
